// File: rtl/fma_pkg.sv
// Shared FMA datapath constants and types.
// The alignment exponent logic and the post-addition normalizer both use
// MSB_OFS so that they agree on where the binary point of the sum sits.
package fma_pkg;
  localparam int SUM_W   = 76;          // sum magnitude width
  localparam int MAN_W   = 27;          // {significand, guard, round, sticky}
  localparam int SIG_W   = MAN_W - 3;   // significand incl. hidden 1
  localparam int EXP_W   = 10;          // signed true exponent width
  localparam int LZC_W   = 7;           // enough to hold 0..SUM_W
  localparam int EMAX    = 127;
  localparam int EMIN    = -126;
  localparam int MSB_OFS = 2;           // sum MSB weight is 2^(exp_tmp+MSB_OFS)

  typedef struct packed {
    logic signed [EXP_W-1:0] exp;
    logic [MAN_W-1:0]        man;
    logic                    zero;
    logic                    ovf;
    logic                    unf;
  } norm_res_t;
endpackage

// File: rtl/exp_normalizer_if.sv
// Handshake and data bundle for the exponent normalizer.
//   slave  : the normalizer side (accepts operands, presents results)
//   master : the surrounding datapath (sends operands, consumes results)
interface exp_normalizer_if;
  import fma_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [EXP_W-1:0] exp_tmp;
  logic [SUM_W-1:0]        sum_mag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [EXP_W-1:0] exp_out;
  logic [MAN_W-1:0]        man_out;
  logic                    zero_flag;
  logic                    ovf_flag;
  logic                    unf_flag;

  modport slave (
    input  in_valid, exp_tmp, sum_mag, out_ready,
    output in_ready, out_valid, exp_out, man_out, zero_flag, ovf_flag, unf_flag
  );

  modport master (
    output in_valid, exp_tmp, sum_mag, out_ready,
    input  in_ready, out_valid, exp_out, man_out, zero_flag, ovf_flag, unf_flag
  );
endinterface

// File: rtl/lzc76.sv
// Combinational leading-zero counter over SUM_W bits.
//   in  : value to scan (MSB first)
//   cnt : number of leading zeros, SUM_W for an all-zero input
module lzc76
  import fma_pkg::*;
(
  input  logic [SUM_W-1:0] in,
  output logic [LZC_W-1:0] cnt
);
  localparam int TREE_W = 1 << LZC_W;

  // Padding the low end with ones bounds the search: an all-zero input hits
  // the first pad bit and naturally reports SUM_W, and every tree node at
  // the root is valid, so no special case is needed.
  function automatic logic [LZC_W-1:0] tree(input logic [TREE_W-1:0] pad);
    logic [TREE_W-1:0]            v;
    logic [TREE_W-1:0][LZC_W-1:0] c;
    for (int i = 0; i < TREE_W; i++) begin
      v[i] = pad[TREE_W-1-i];
      c[i] = '0;
    end
    // Node i of level l merges nodes 2i (upper half) and 2i+1 (lower half)
    // of level l-1; in-place update is safe because 2i >= i.
    for (int l = 1; l <= LZC_W; l++) begin
      for (int i = 0; i < (TREE_W >> l); i++) begin
        c[i] = v[2*i] ? c[2*i] : (c[2*i+1] | LZC_W'(1 << (l-1)));
        v[i] = v[2*i] | v[2*i+1];
      end
    end
    return c[0];
  endfunction

  always_comb cnt = tree({in, {(TREE_W-SUM_W){1'b1}}});
endmodule

// File: rtl/exp_normalizer.sv
// Post-addition normalizer of the FMA datapath.
// S1 registers the operands and counts leading zeros, S2 shifts the sum and
// adjusts the exponent, S3 packs {significand, G, R, S} and range flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of exp_normalizer_if (valid/ready in and out)
module exp_normalizer
  import fma_pkg::*;
(
  input logic            clk,
  input logic            rst,
  exp_normalizer_if.slave bus
);
  localparam int STAGES = 3;

  logic [STAGES:0]         vld_pipe;
  logic                    stall;
  logic signed [EXP_W-1:0] s1_exp, s2_exp;
  logic [SUM_W-1:0]        s1_sum, s2_sh;
  logic                    s2_zero;
  logic [LZC_W-1:0]        lzc;
  norm_res_t               s3, s3_nxt;

  // Whole pipe freezes on output backpressure; otherwise bubbles advance.
  assign stall        = vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign vld_pipe[0]  = bus.in_valid;

  lzc76 u_lzc (.in(s1_sum), .cnt(lzc));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      s3                 <= '0;
    end else if (!stall) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      s3                 <= s3_nxt;
    end
  end

  // Data stages carry no reset; their contents only matter under a valid.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_exp  <= bus.exp_tmp;
      s1_sum  <= bus.sum_mag;
      s2_sh   <= s1_sum << lzc;
      s2_exp  <= s1_exp + EXP_W'(MSB_OFS)
                 - $signed({{(EXP_W-LZC_W){1'b0}}, lzc});
      s2_zero <= (lzc == LZC_W'(SUM_W));
    end
  end

  always_comb begin
    s3_nxt      = '0;
    s3_nxt.zero = s2_zero;
    s3_nxt.man  = {s2_sh[SUM_W-1 -: SIG_W],
                   s2_sh[SUM_W-SIG_W-1],
                   s2_sh[SUM_W-SIG_W-2],
                   |s2_sh[SUM_W-SIG_W-3:0]};
    // Zero result: exponent is meaningless, report a clean zero instead.
    if (!s2_zero) begin
      s3_nxt.exp = s2_exp;
      s3_nxt.ovf = s2_exp > EMAX;
      s3_nxt.unf = s2_exp < EMIN;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.exp_out   = s3.exp;
  assign bus.man_out   = s3.man;
  assign bus.zero_flag = s3.zero;
  assign bus.ovf_flag  = s3.ovf;
  assign bus.unf_flag  = s3.unf;
endmodule

// File: tb/tb_exp_normalizer.sv
module tb_exp_normalizer;
  import fma_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exp_normalizer_if bus ();
  exp_normalizer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string                   nm;
    logic signed [EXP_W-1:0] et;
    logic [SUM_W-1:0]        sm;
    logic signed [EXP_W-1:0] ee;
    logic [MAN_W-1:0]        me;
    logic                    z, o, u;
  } vec_t;

  localparam int NV = 16;
  vec_t tv[NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input string nm, input int et, input logic [SUM_W-1:0] sm,
                              input int ee, input logic [MAN_W-1:0] me,
                              input logic z, input logic o, input logic u);
    vec_t v;
    v.nm = nm; v.et = EXP_W'(et); v.sm = sm; v.ee = EXP_W'(ee); v.me = me;
    v.z = z; v.o = o; v.u = u;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.exp_tmp   = v.et;
    bus.sum_mag   = v.sm;
    bus.out_ready = 1'b1;
    lat  = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
      if (bus.out_valid) seen = 1;
    end
    chk({v.nm, " seen"}, longint'(seen), 1);
    chk({v.nm, " latency"}, lat, 3);
    chk({v.nm, " exp_out"}, $signed(bus.exp_out), v.ee);
    chk({v.nm, " man_out"}, bus.man_out, v.me);
    chk({v.nm, " zero"}, bus.zero_flag, v.z);
    chk({v.nm, " ovf"}, bus.ovf_flag, v.o);
    chk({v.nm, " unf"}, bus.unf_flag, v.u);
  endtask

  initial begin
    logic [SUM_W-1:0] one;
    int  sent, got, stall_cyc;
    bit  exp_stall, seen;
    one = 1;

    tv[0]  = mk("top",       0,   one << 75,               2,    27'h4000000, 0, 0, 0);
    tv[1]  = mk("lsb",       10,  one,                     -63,  27'h4000000, 0, 0, 0);
    tv[2]  = mk("zero",      50,  '0,                      0,    27'h0,       1, 0, 0);
    tv[3]  = mk("ovf",       200, one << 75,               202,  27'h4000000, 0, 1, 0);
    tv[4]  = mk("unf",       -200, one << 40,              -233, 27'h4000000, 0, 0, 1);
    tv[5]  = mk("sticky",    0,   (one << 75) | one,       2,    27'h4000001, 0, 0, 0);
    tv[6]  = mk("round",     0,   (one << 75) | (one << 74) | (one << 50), 2, 27'h6000002, 0, 0, 0);
    tv[7]  = mk("guard",     0,   (one << 75) | (one << 51), 2,  27'h4000004, 0, 0, 0);
    tv[8]  = mk("emax",      125, one << 75,               127,  27'h4000000, 0, 0, 0);
    tv[9]  = mk("emax+1",    126, one << 75,               128,  27'h4000000, 0, 1, 0);
    tv[10] = mk("emin",      -128, one << 75,              -126, 27'h4000000, 0, 0, 0);
    tv[11] = mk("emin-1",    -129, one << 75,              -127, 27'h4000000, 0, 0, 1);
    tv[12] = mk("mid",       0,   (one << 52) | (one << 51), -21, 27'h6000000, 0, 0, 0);
    tv[13] = mk("three",     0,   one | (one << 1) | (one << 2), -71, 27'h7000000, 0, 0, 0);
    tv[14] = mk("min range", -256, one,                    -329, 27'h4000000, 0, 0, 1);
    tv[15] = mk("max range", 281, one << 75,               283,  27'h4000000, 0, 1, 0);

    bus.in_valid  = 1'b0;
    bus.exp_tmp   = '0;
    bus.sum_mag   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst exp_out", $signed(bus.exp_out), 0);
    chk("rst man_out", bus.man_out, 0);
    chk("rst flags", {bus.zero_flag, bus.ovf_flag, bus.unf_flag}, 0);
    chk("rst in_ready", bus.in_ready, 1);

    for (int i = 0; i < NV; i++) run_vec(tv[i]);

    // Streaming with a 4-cycle backpressure window; item k carries sum
    // (1<<75)>>k and exp_tmp 3k, so the result exponent is 2k+2.
    sent = 0; got = 0; stall_cyc = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 5 && cyc < 9);
      #1;
      exp_stall = bus.out_valid && !bus.out_ready;
      if (exp_stall) stall_cyc++;
      chk("stream in_ready", bus.in_ready, !exp_stall);
      if (bus.out_valid && bus.out_ready) begin
        chk("stream exp_out", $signed(bus.exp_out), 2*got + 2);
        chk("stream man_out", bus.man_out, 27'h4000000);
        got++;
      end
      if (bus.in_ready && sent < 6) begin
        bus.in_valid = 1'b1;
        bus.exp_tmp  = EXP_W'(3*sent);
        bus.sum_mag  = (one << 75) >> sent;
        sent++;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    chk("stream count", got, 6);
    chk("stream stall cycles", stall_cyc, 4);

    // Reset with two items in flight: nothing may emerge afterwards.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.exp_tmp   = 10'sd5;
    bus.sum_mag   = one << 75;
    @(negedge clk);
    bus.exp_tmp   = 10'sd6;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("flush out_valid", bus.out_valid, 0);
    chk("flush in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("flush no output", longint'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exp_normalizer.md
Name: exp_normalizer

Overview:
- Post-addition stage of the FMA datapath. It is the counterpart of the alignment exponent logic.
- Accepts the unnormalized sum magnitude and the pre-normalization exponent (exp_tmp, true value, signed).
- Counts leading zeros and left-shifts the sum to a normalized mantissa with guard, round and sticky bits.
- Adjusts the exponent and flags zero, overflow and underflow for the rounding stage that follows.
- 3-stage pipeline with a valid/ready handshake.

Parameters:
- SUM_W, 76: sum magnitude width. Bit SUM_W-1 carries weight 2^(exp_tmp+2).
- MAN_W, 27: output mantissa width. 24 significand bits (hidden 1 included) plus guard, round and sticky.
- EXP_W, 10: signed exponent width for input and output, two's complement, true value (unbiased).
- EMAX, 127: largest normal exponent.
- EMIN, -126: smallest normal exponent.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input operand valid.
- in_ready, output, 1: block can accept an input this cycle.
- exp_tmp, input, EXP_W: pre-normalization exponent, signed true value.
- sum_mag, input, SUM_W: unsigned sum magnitude.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- exp_out, output, EXP_W: normalized exponent, signed true value.
- man_out, output, MAN_W: {24-bit significand, guard, round, sticky}.
- zero_flag, output, 1: sum_mag was zero.
- ovf_flag, output, 1: exp_out > EMAX.
- unf_flag, output, 1: exp_out < EMIN (no denormal support).

Behaviour:
- Reset: one clk edge with rst=1 clears all stage valids. out_valid, exp_out, man_out and all flags become 0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation drops every in-flight item with no output.
- Handshake:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall, which is combinational from out_ready.
  - During a stall all three stages hold their contents. No item is lost, duplicated or reordered.
  - With no stall, bubbles advance: a stage is loaded with its predecessor's valid and data.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: 3 cycles from input transfer to out_valid when there is no stall. Throughput is 1 per cycle.
- S1: register exp_tmp and sum_mag. Compute lzc = number of leading zeros of sum_mag, range 0..SUM_W (76 when zero), width 7.
- S2:
  - shifted = sum_mag << lzc, SUM_W wide.
  - exp_norm = exp_tmp + 2 - lzc, computed in EXP_W signed arithmetic. The range is [-329, 283], so no wrap occurs.
  - Register both, plus the zero indication (lzc == SUM_W).
- S3 (output register):
  - man_out[26:3] = shifted[75:52].
  - guard = shifted[51], round = shifted[50], sticky = OR of shifted[49:0].
  - ovf_flag = exp_norm > EMAX; unf_flag = exp_norm < EMIN, using signed compares.
  - exp_out = exp_norm, with no saturation; saturation is the rounder's job.
- Zero case: exp_out = 0, man_out = 0, zero_flag = 1, ovf_flag = unf_flag = 0.
- Flags are mutually exclusive.
- Non-zero results always have man_out[26] = 1.

Decomposition:
- Shared package fma_pkg holds:
  - SUM_W, MAN_W, EXP_W, EMAX, EMIN;
  - the MSB weight offset constant (2), shared with the alignment exponent logic so both ends agree on the sum's binary point.
- One sub-module, lzc76: combinational leading-zero counter for SUM_W bits, returning a 7-bit count, 76 for an all-zero input. It uses a tree encoding and is instantiated in S1.

Test Plan:
- Top bit set: exp_tmp=0, sum_mag=1<<75 → 3 cycles later exp_out=2, man_out=27'h4000000, all flags 0.
- LSB only: exp_tmp=10, sum_mag=1 → exp_out=-63, man_out=27'h4000000, sticky=0.
- Zero sum: exp_tmp=50, sum_mag=0 → zero_flag=1, exp_out=0, man_out=0, ovf_flag=unf_flag=0.
- Range flags:
  - exp_tmp=200, sum_mag=1<<75 → exp_out=202, ovf_flag=1.
  - exp_tmp=-200, sum_mag=1<<40 → exp_out=-233, unf_flag=1.
- Guard/round/sticky: sum_mag=(1<<75)|1 → man_out=27'h4000001 (sticky=1). sum_mag=(3<<74)|(1<<50) → man_out=27'h6000002 (round=1).
- Backpressure and reset: stream 6 back-to-back items with out_ready low for 4 cycles mid-stream.
  - Required: in_ready=0 exactly while stalled, all 6 outputs in order with none dropped.
  - Then assert rst with 2 items in flight → no outputs follow, and out_valid=0 the next cycle.
